// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB command responder: opcodes, status codes,
// word field positions and the control FSM state encoding.
package usb_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_PING  = 8'h03;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADOP   = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADTAG  = 8'h03;

  localparam int RSV_MSB = 39;
  localparam int RSV_LSB = 36;
  localparam int TAG_MSB = 35;
  localparam int TAG_LSB = 32;
  localparam int PAY_MSB = 31;
  localparam int PAY_LSB = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_RD,
    S_DECODE,
    S_WR_RD,
    S_WR_EXEC,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_PUSH,
    S_ACK
  } state_t;

  // Header payload layout: opcode, start address, word count.
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  cnt;
  } hdr_t;

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/usb_cmd_tx_pack.sv
// Builds the 40-bit TX word from tag and payload, and freezes it while the
// TX FIFO back-pressures so the word cannot change before it is accepted.
module usb_cmd_tx_pack
  import usb_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [3:0]  tag,
  input  logic [31:0] payload,
  input  logic        tx_full,
  output logic [39:0] tx_data,
  output logic        tx_we
);

  logic [39:0] word_now;
  logic [39:0] word_q;
  logic        held_q;

  assign word_now = {4'h0, tag, payload};
  assign tx_we    = tx_req & ~tx_full;
  assign tx_data  = held_q ? word_q : (tx_req ? word_now : '0);

  // First stalled cycle captures the word; it is replayed until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= 1'b0;
      word_q <= '0;
    end else if (!tx_req || tx_we) begin
      held_q <= 1'b0;
    end else if (!held_q) begin
      held_q <= 1'b1;
      word_q <= word_now;
    end
  end

endmodule

// File: rtl/usb_cmd_responder.sv
// Consumes host command frames from the RX FIFO, executes them on the
// internal register bus and returns read data plus an ack word on the TX FIFO.
module usb_cmd_responder
  import usb_cmd_pkg::*;
#(
  parameter int         RD_TIMEOUT = 64,
  parameter logic [7:0] ACK_MARK   = 8'hA5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  Communication_Number,
  input  logic [39:0] RX_FIFO_Data,
  input  logic        RX_FIFO_EMPTY,
  output logic        RX_FIFO_RE,
  output logic [39:0] TX_FIFO_Data,
  output logic        TX_FIFO_WE,
  input  logic        TX_FULL,
  output logic [15:0] REG_ADDR,
  output logic [31:0] REG_WDATA,
  output logic        REG_WE,
  output logic        REG_RE,
  input  logic [31:0] REG_RDATA,
  input  logic        REG_RVALID,
  output logic        BUSY
);

  localparam int             WCW       = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_TIMEOUT - 1);

  state_t         state_q, state_d;
  hdr_t           hdr_in;
  logic [3:0]     tag_in;
  logic           tag_ok_in;
  logic [7:0]     dec_status;
  logic [7:0]     op_q, n_q, st_q;
  logic [15:0]    base_q;
  logic           tag_ok_q;
  logic [8:0]     cnt_q, cnt_inc;
  logic           last_item;
  logic [WCW-1:0] wcnt_q;
  logic [31:0]    rdata_q;
  logic [15:0]    reg_addr_q;
  logic [31:0]    reg_wdata_q;
  logic           reg_we_q, reg_re_q;
  logic           tx_req, tx_we;
  logic [31:0]    tx_payload, ack_payload;
  logic           unused_rsvd;

  assign hdr_in      = hdr_t'(RX_FIFO_Data[PAY_MSB:PAY_LSB]);
  assign tag_in      = RX_FIFO_Data[TAG_MSB:TAG_LSB];
  assign unused_rsvd = ^RX_FIFO_Data[RSV_MSB:RSV_LSB];
  assign tag_ok_in   = (tag_in == Communication_Number);
  assign cnt_inc     = cnt_q + 9'd1;
  assign last_item   = (cnt_inc == {1'b0, n_q});
  assign ack_payload = {op_q, st_q, sat8(cnt_q), ACK_MARK};

  assign BUSY       = (state_q != S_IDLE);
  assign REG_ADDR   = reg_addr_q;
  assign REG_WDATA  = reg_wdata_q;
  assign REG_WE     = reg_we_q;
  assign REG_RE     = reg_re_q;
  assign TX_FIFO_WE = tx_we;

  // Tag is judged before opcode, so a foreign frame never reports BADOP.
  always_comb begin
    dec_status = ST_BADOP;
    if (!tag_ok_in)
      dec_status = ST_BADTAG;
    else if (hdr_in.op == OP_WRITE || hdr_in.op == OP_READ || hdr_in.op == OP_PING)
      dec_status = ST_OK;
  end

  always_comb begin
    state_d    = state_q;
    RX_FIFO_RE = 1'b0;
    tx_req     = 1'b0;
    tx_payload = rdata_q;
    case (state_q)
      S_IDLE:    if (!RX_FIFO_EMPTY) state_d = S_HDR_RD;
      S_HDR_RD: begin
        if (!RX_FIFO_EMPTY) begin
          RX_FIFO_RE = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // A mistagged WRITE still drains its data words.
        if (hdr_in.op == OP_WRITE && dec_status != ST_BADOP && hdr_in.cnt != 8'd0)
          state_d = S_WR_RD;
        else if (hdr_in.op == OP_READ && dec_status == ST_OK && hdr_in.cnt != 8'd0)
          state_d = S_RD_REQ;
        else
          state_d = S_ACK;
      end
      S_WR_RD: begin
        if (!RX_FIFO_EMPTY) begin
          RX_FIFO_RE = 1'b1;
          state_d    = S_WR_EXEC;
        end
      end
      S_WR_EXEC: state_d = last_item ? S_ACK : S_WR_RD;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (REG_RVALID)
          state_d = S_RD_PUSH;
        else if (wcnt_q == WAIT_LAST)
          state_d = S_ACK;
      end
      S_RD_PUSH: begin
        tx_req = 1'b1;
        if (tx_we) state_d = last_item ? S_ACK : S_RD_REQ;
      end
      S_ACK: begin
        tx_req     = 1'b1;
        tx_payload = ack_payload;
        if (tx_we) state_d = S_IDLE;
      end
      default:   state_d = S_IDLE;
    endcase
  end

  // Register-bus strobes are registered, so they appear one cycle after the
  // state that issues them; the read wait counter starts at the REG_RE cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      n_q         <= '0;
      st_q        <= '0;
      base_q      <= '0;
      tag_ok_q    <= 1'b0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      rdata_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_we_q <= 1'b0;
      reg_re_q <= 1'b0;
      case (state_q)
        S_DECODE: begin
          op_q     <= hdr_in.op;
          base_q   <= hdr_in.addr;
          n_q      <= hdr_in.cnt;
          tag_ok_q <= tag_ok_in;
          st_q     <= dec_status;
          cnt_q    <= '0;
        end
        S_WR_EXEC: begin
          if (tag_ok_q) begin
            reg_we_q    <= 1'b1;
            reg_addr_q  <= base_q + {8'h00, cnt_q[7:0]};
            reg_wdata_q <= RX_FIFO_Data[PAY_MSB:PAY_LSB];
          end
          cnt_q <= cnt_inc;
        end
        S_RD_REQ: begin
          reg_re_q   <= 1'b1;
          reg_addr_q <= base_q + {8'h00, cnt_q[7:0]};
          wcnt_q     <= '0;
        end
        S_RD_WAIT: begin
          if (REG_RVALID)
            rdata_q <= REG_RDATA;
          else if (wcnt_q == WAIT_LAST)
            st_q <= ST_TIMEOUT;
          else
            wcnt_q <= wcnt_q + 1'b1;
        end
        S_RD_PUSH: if (tx_we) cnt_q <= cnt_inc;
        default: ;
      endcase
    end
  end

  usb_cmd_tx_pack u_tx_pack (
    .clk     (CLK),
    .rst     (RST),
    .tx_req  (tx_req),
    .tag     (Communication_Number),
    .payload (tx_payload),
    .tx_full (TX_FULL),
    .tx_data (TX_FIFO_Data),
    .tx_we   (tx_we)
  );

endmodule

// File: tb/tb_usb_cmd_responder.sv
// Scoreboard bench for usb_cmd_responder: frames are expanded by a reference
// model into expected TX words and register accesses; a monitor pops and compares.
module tb_usb_cmd_responder;

  localparam int RD_TIMEOUT = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  Communication_Number = 4'h5;
  logic [39:0] RX_FIFO_Data = '0;
  logic        RX_FIFO_EMPTY = 1'b1;
  logic        RX_FIFO_RE;
  logic [39:0] TX_FIFO_Data;
  logic        TX_FIFO_WE;
  logic        TX_FULL = 1'b0;
  logic [15:0] REG_ADDR;
  logic [31:0] REG_WDATA;
  logic        REG_WE;
  logic        REG_RE;
  logic [31:0] REG_RDATA = '0;
  logic        REG_RVALID = 1'b0;
  logic        BUSY;

  always #5 CLK = ~CLK;

  usb_cmd_responder #(.RD_TIMEOUT(RD_TIMEOUT), .ACK_MARK(8'hA5)) dut (
    .CLK(CLK), .RST(RST), .Communication_Number(Communication_Number),
    .RX_FIFO_Data(RX_FIFO_Data), .RX_FIFO_EMPTY(RX_FIFO_EMPTY), .RX_FIFO_RE(RX_FIFO_RE),
    .TX_FIFO_Data(TX_FIFO_Data), .TX_FIFO_WE(TX_FIFO_WE), .TX_FULL(TX_FULL),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_WE(REG_WE), .REG_RE(REG_RE),
    .REG_RDATA(REG_RDATA), .REG_RVALID(REG_RVALID), .BUSY(BUSY)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [39:0] rxq[$];
  logic [39:0] exp_tx[$];
  logic [47:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  int          rd_lat[$];
  logic [31:0] rd_dat[$];
  logic [31:0] force_dat[$];
  int          force_lat[$];

  bit          rand_full = 0, rand_empty = 0, hold_on_rv = 0, inject = 0, do_flush = 0;
  int          full_hold = 0, wr_seen = 0;
  bit          re_prev = 0, pend = 0;
  int          pend_cd = 0, mon_lat;
  logic [31:0] pend_dat = '0, mon_dat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic note_unexpected(input string name, input logic [63:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %0s: got %0h, expected nothing", name, act);
  endtask

  // Environment: RX FIFO (read latency 1), TX FIFO back-pressure, register
  // responder; inputs change on the falling edge, outputs sampled 1 ns later.
  always @(negedge CLK) begin
    if (do_flush) begin
      rxq.delete(); exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
      rd_lat.delete(); rd_dat.delete();
      pend = 0; re_prev = 0; do_flush = 0;
    end else if (re_prev) begin
      re_prev = 0;
      if (rxq.size() > 0) RX_FIFO_Data = rxq.pop_front();
    end
    RX_FIFO_EMPTY = (rxq.size() == 0) || (rand_empty && $urandom_range(0, 2) == 0);
    TX_FULL = (full_hold > 0) || (rand_full && $urandom_range(0, 3) == 0);
    if (full_hold > 0) full_hold--;
    REG_RVALID = 1'b0;
    if (pend) begin
      if (pend_cd == 0) begin
        REG_RVALID = 1'b1; REG_RDATA = pend_dat; pend = 0;
        if (hold_on_rv) full_hold = 10;
      end else pend_cd--;
    end else if (inject) begin
      REG_RVALID = 1'b1; REG_RDATA = 32'hBAD0BAD0; inject = 0;
    end
    #1;
    if (RX_FIFO_RE) begin
      check("re_while_empty", RX_FIFO_EMPTY, 0);
      re_prev = 1;
    end
    if (TX_FIFO_WE) begin
      if (exp_tx.size() == 0) note_unexpected("tx_unexpected", TX_FIFO_Data);
      else check("tx_word", TX_FIFO_Data, exp_tx.pop_front());
    end
    if (REG_WE) begin
      wr_seen++;
      if (exp_wr.size() == 0) note_unexpected("reg_we_unexpected", {REG_ADDR, REG_WDATA});
      else check("reg_write", {REG_ADDR, REG_WDATA}, exp_wr.pop_front());
    end
    if (REG_RE) begin
      if (exp_rd.size() == 0) note_unexpected("reg_re_unexpected", REG_ADDR);
      else check("reg_read_addr", REG_ADDR, exp_rd.pop_front());
      if (rd_lat.size() > 0) begin
        mon_lat = rd_lat.pop_front();
        mon_dat = rd_dat.pop_front();
        if (mon_lat > 0) begin pend = 1; pend_cd = mon_lat - 1; pend_dat = mon_dat; end
      end
    end
  end

  // Reference model: expands one frame into RX words and expected effects.
  // drop >= 0 makes that read index never answer.
  task automatic send_frame(input logic [3:0] tag, input logic [7:0] op,
                            input logic [15:0] addr, input int n, input int drop);
    logic [7:0]  st;
    logic [31:0] d;
    logic [15:0] a;
    int          done, lat;
    done = 0;
    rxq.push_back({4'h0, tag, op, addr, 8'(n)});
    if (tag != Communication_Number) st = 8'h03;
    else if (op == 8'h01 || op == 8'h02 || op == 8'h03) st = 8'h00;
    else st = 8'h01;
    if (op == 8'h01 && st != 8'h01) begin
      for (int i = 0; i < n; i++) begin
        d = (force_dat.size() > 0) ? force_dat.pop_front() : $urandom;
        rxq.push_back({4'h0, tag, d});
        if (st == 8'h00) exp_wr.push_back({addr + 16'(i), d});
      end
      done = n;
    end
    if (op == 8'h02 && st == 8'h00) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 16'(i);
        exp_rd.push_back(a);
        if (i == drop) begin
          rd_lat.push_back(0); rd_dat.push_back(32'h0);
          st = 8'h02;
          break;
        end
        d   = (force_dat.size() > 0) ? force_dat.pop_front() : $urandom;
        lat = (force_lat.size() > 0) ? force_lat.pop_front() : $urandom_range(1, 6);
        rd_lat.push_back(lat); rd_dat.push_back(d);
        exp_tx.push_back({4'h0, Communication_Number, d});
        done++;
      end
    end
    exp_tx.push_back({4'h0, Communication_Number, op, st,
                      (done > 255) ? 8'hFF : 8'(done), 8'hA5});
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    @(negedge CLK); #2;
    while ((exp_tx.size() != 0 || BUSY || rxq.size() != 0) && cyc < 3000) begin
      @(negedge CLK); #2;
      cyc++;
    end
    n_chk++;
    if (cyc >= 3000) begin
      n_fail++;
      $display("FAIL %0s: frame still open after %0d cycles, %0d tx words missing", name, cyc, exp_tx.size());
    end
    check({name, "_wr_left"}, exp_wr.size(), 0);
    check({name, "_rd_left"}, exp_rd.size(), 0);
  endtask

  task automatic check_zero(input string name);
    check(name, {RX_FIFO_RE, TX_FIFO_WE, REG_WE, REG_RE, BUSY}, 0);
    check({name, "_buses"}, {REG_ADDR, REG_WDATA, TX_FIFO_Data}, 0);
  endtask

  initial begin
    int target, cyc, n, drop;
    logic [7:0]  op;
    logic [3:0]  tag;
    logic [15:0] addr;

    repeat (3) @(negedge CLK);
    #2 check_zero("reset_state");
    RST = 1'b0;

    force_dat = '{32'h11, 32'h22, 32'h33};
    send_frame(4'h5, 8'h01, 16'h0010, 3, -1);
    wait_idle("write3");

    force_dat = '{32'hDEADBEEF, 32'h12345678};
    force_lat = '{3, 3};
    send_frame(4'h5, 8'h02, 16'hFFFF, 2, -1);
    wait_idle("read_wrap");

    send_frame(4'h5, 8'h02, 16'h0300, 4, 2);
    wait_idle("read_timeout");
    inject = 1;
    repeat (10) @(negedge CLK);
    wait_idle("late_rvalid");

    send_frame(4'h3, 8'h01, 16'h0100, 2, -1);
    wait_idle("badtag_write");
    send_frame(4'h5, 8'h7F, 16'h0000, 5, -1);
    wait_idle("badop");
    send_frame(4'h5, 8'h03, 16'h1234, 0, -1);
    wait_idle("ping");
    send_frame(4'h5, 8'h02, 16'h0000, 0, -1);
    wait_idle("read_n0");

    rand_empty = 1; hold_on_rv = 1;
    send_frame(4'h5, 8'h02, 16'h0040, 3, -1);
    send_frame(4'h5, 8'h01, 16'h0050, 5, -1);
    wait_idle("full_hold");
    hold_on_rv = 0;

    rand_full = 1;
    send_frame(4'h5, 8'h01, 16'hFF80, 255, -1);
    wait_idle("write255");

    rand_full = 0; rand_empty = 0;
    send_frame(4'h5, 8'h01, 16'h0200, 6, -1);
    target = wr_seen + 2;
    cyc = 0;
    while (wr_seen < target && cyc < 500) begin @(negedge CLK); #2; cyc++; end
    check("reset_reach_mid_write", (wr_seen >= target), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    do_flush = 1;
    @(negedge CLK); #2;
    check_zero("reset_mid_write");
    repeat (8) @(negedge CLK);
    #2 check("idle_after_reset", BUSY, 0);
    send_frame(4'h5, 8'h03, 16'h0000, 0, -1);
    wait_idle("ping_after_reset");

    rand_full = 1; rand_empty = 1;
    for (int f = 0; f < 40; f++) begin
      tag  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h5;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 8'h01;
        4, 5, 6, 7: op = 8'h02;
        8:          op = 8'h03;
        default:    op = 8'($urandom);
      endcase
      n    = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 5);
      addr = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      drop = (op == 8'h02 && n > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
      send_frame(tag, op, addr, n, drop);
      wait_idle("random_frame");
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
